// File: rtl/exec_forward_pipe.sv
// EX/DM/WB pipeline: operand forwarding, data-memory drive and regfile write port.
// Optional `FWD_STATS_EN adds a saturating forwarded-operand counter (fwd_count).
module exec_forward_pipe #(
    parameter int DATA_W = 8,
    parameter int REG_W  = 5,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   op_dec,
    input  logic [REG_W-1:0]  RW_dec,
    input  logic [1:0]        mux_sel_a,
    input  logic [1:0]        mux_sel_b,
    input  logic              imm_sel,
    input  logic [DATA_W-1:0] Imm,
    input  logic              mem_en_dec,
    input  logic              mem_rw_dec,
    input  logic              mem_mux_sel_dec,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [OP_W-1:0]   op_exec,
    output logic [DATA_W-1:0] ans_a,
    output logic [DATA_W-1:0] ans_b,
    output logic [DATA_W-1:0] ans_ex,
    output logic [DATA_W-1:0] ans_dm,
    output logic [DATA_W-1:0] ans_wb,
    output logic              mem_en_ex,
    output logic              mem_rw_ex,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              wr_en_wb,
    output logic [REG_W-1:0]  RW_wb
`ifdef FWD_STATS_EN
    ,
    output logic [15:0]       fwd_count
`endif
);

    localparam logic [OP_W-1:0] OP_STORE = OP_W'(5'b10101);

    logic [DATA_W-1:0] ans_ex_q, ans_ex_d;
    logic              v_ex_q, v_ex_d;
    logic [REG_W-1:0]  rw_ex_q, rw_ex_d;
    logic [OP_W-1:0]   op_ex_q, op_ex_d;
    logic              mem_en_ex_q, mem_en_ex_d;
    logic              mem_rw_ex_q, mem_rw_ex_d;
    logic              msel_ex_q, msel_ex_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [DATA_W-1:0] ans_dm_q, ans_dm_d;
    logic [REG_W-1:0]  rw_dm_q, rw_dm_d;
    logic              we_dm_q, we_dm_d;
    logic              v_dm_q, v_dm_d;

    logic [DATA_W-1:0] ans_wb_q, ans_wb_d;
    logic [REG_W-1:0]  rw_wb_q, rw_wb_d;
    logic              wr_en_wb_q, wr_en_wb_d;

    logic [DATA_W-1:0] a_fwd, b_fwd;

    function automatic logic writes(input logic [OP_W-1:0] op);
        return !((op == OP_STORE) || (op[OP_W-1 -: 2] == 2'b11));
    endfunction

    function automatic logic [DATA_W-1:0] fwd_mux(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] rf
    );
        logic [DATA_W-1:0] r;
        case (sel)
            2'b01:   r = ans_ex_q;
            2'b10:   r = ans_dm_q;
            2'b11:   r = ans_wb_q;
            default: r = rf;
        endcase
        return r;
    endfunction

    always_comb begin
        a_fwd = fwd_mux(mux_sel_a, rd_data_a);
        b_fwd = fwd_mux(mux_sel_b, rd_data_b);
    end

    assign ans_a   = a_fwd;
    assign ans_b   = imm_sel ? Imm : b_fwd;
    assign op_exec = op_dec;

    always_comb begin
        ans_ex_d    = alu_result;
        v_ex_d      = 1'b1;
        rw_ex_d     = RW_dec;
        op_ex_d     = op_dec;
        mem_en_ex_d = mem_en_dec;
        mem_rw_ex_d = mem_rw_dec;
        msel_ex_d   = mem_mux_sel_dec;
        // store data comes from the register path even when B is an immediate
        mem_wdata_d = b_fwd;

        ans_dm_d = msel_ex_q ? mem_rd_data : ans_ex_q;
        rw_dm_d  = rw_ex_q;
        we_dm_d  = v_ex_q & writes(op_ex_q);
        v_dm_d   = v_ex_q;

        ans_wb_d   = ans_dm_q;
        rw_wb_d    = rw_dm_q;
        wr_en_wb_d = we_dm_q & v_dm_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ans_ex_q    <= '0;
            v_ex_q      <= 1'b0;
            rw_ex_q     <= '0;
            op_ex_q     <= '0;
            mem_en_ex_q <= 1'b0;
            mem_rw_ex_q <= 1'b0;
            msel_ex_q   <= 1'b0;
            mem_wdata_q <= '0;
            ans_dm_q    <= '0;
            rw_dm_q     <= '0;
            we_dm_q     <= 1'b0;
            v_dm_q      <= 1'b0;
            ans_wb_q    <= '0;
            rw_wb_q     <= '0;
            wr_en_wb_q  <= 1'b0;
        end else begin
            ans_ex_q    <= ans_ex_d;
            v_ex_q      <= v_ex_d;
            rw_ex_q     <= rw_ex_d;
            op_ex_q     <= op_ex_d;
            mem_en_ex_q <= mem_en_ex_d;
            mem_rw_ex_q <= mem_rw_ex_d;
            msel_ex_q   <= msel_ex_d;
            mem_wdata_q <= mem_wdata_d;
            ans_dm_q    <= ans_dm_d;
            rw_dm_q     <= rw_dm_d;
            we_dm_q     <= we_dm_d;
            v_dm_q      <= v_dm_d;
            ans_wb_q    <= ans_wb_d;
            rw_wb_q     <= rw_wb_d;
            wr_en_wb_q  <= wr_en_wb_d;
        end
    end

    assign ans_ex    = ans_ex_q;
    assign ans_dm    = ans_dm_q;
    assign ans_wb    = ans_wb_q;
    assign mem_en_ex = mem_en_ex_q;
    assign mem_rw_ex = mem_rw_ex_q;
    assign mem_addr  = ans_ex_q;
    assign mem_wdata = mem_wdata_q;
    assign wr_en_wb  = wr_en_wb_q;
    assign RW_wb     = rw_wb_q;

`ifdef FWD_STATS_EN
    logic [15:0] fwd_count_q, fwd_count_d;
    logic [1:0]  n_fwd;
    logic [16:0] fwd_sum;

    always_comb begin
        n_fwd = {1'b0, (mux_sel_a != 2'b00)}
              + {1'b0, (mux_sel_b != 2'b00) & ~imm_sel};
        fwd_sum = {1'b0, fwd_count_q} + {15'b0, n_fwd};
        fwd_count_d = fwd_sum[16] ? 16'hFFFF : fwd_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fwd_count_q <= '0;
        else        fwd_count_q <= fwd_count_d;
    end

    assign fwd_count = fwd_count_q;
`endif

endmodule

// File: tb/tb_exec_forward_pipe.sv
// Bench for exec_forward_pipe: select-decode table plus a writeback scoreboard.
// Covers reset, forwarding distances, load/store/jump and mid-stream reset.
module tb_exec_forward_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] op_dec, RW_dec;
    logic [1:0] mux_sel_a, mux_sel_b;
    logic       imm_sel;
    logic [7:0] Imm;
    logic       mem_en_dec, mem_rw_dec, mem_mux_sel_dec;
    logic [7:0] rd_data_a, rd_data_b, alu_result, mem_rd_data;
    logic [4:0] op_exec;
    logic [7:0] ans_a, ans_b, ans_ex, ans_dm, ans_wb;
    logic       mem_en_ex, mem_rw_ex;
    logic [7:0] mem_addr, mem_wdata;
    logic       wr_en_wb;
    logic [4:0] RW_wb;
`ifdef FWD_STATS_EN
    logic [15:0] fwd_count;
`endif

    exec_forward_pipe dut (
        .clk(clk), .reset(reset),
        .op_dec(op_dec), .RW_dec(RW_dec),
        .mux_sel_a(mux_sel_a), .mux_sel_b(mux_sel_b),
        .imm_sel(imm_sel), .Imm(Imm),
        .mem_en_dec(mem_en_dec), .mem_rw_dec(mem_rw_dec),
        .mem_mux_sel_dec(mem_mux_sel_dec),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .alu_result(alu_result), .mem_rd_data(mem_rd_data),
        .op_exec(op_exec), .ans_a(ans_a), .ans_b(ans_b),
        .ans_ex(ans_ex), .ans_dm(ans_dm), .ans_wb(ans_wb),
        .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .wr_en_wb(wr_en_wb), .RW_wb(RW_wb)
`ifdef FWD_STATS_EN
        , .fwd_count(fwd_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [4:0] rw;
        logic [7:0] d;
    } wb_t;

    typedef struct {
        logic [1:0] sel;
        logic       imm;
        logic [7:0] b;
        logic [7:0] wd;
    } vec_t;

    wb_t  sb[$];
    vec_t tbl[8];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic writes(input logic [4:0] op);
        return !(op == 5'b10101 || op[4:3] == 2'b11);
    endfunction

    task automatic step(input logic [4:0] op, input logic [4:0] rw,
                        input logic [7:0] alu, input logic msel);
        wb_t e;
        op_dec          = op;
        RW_dec          = rw;
        alu_result      = alu;
        mem_mux_sel_dec = msel;
        mem_rw_dec      = (op == 5'b10101);
        mem_en_dec      = msel | mem_rw_dec;
        e.we = writes(op);
        e.rw = rw;
        e.d  = msel ? mem_rd_data : alu;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 3) begin
            e = sb.pop_front();
            chk("wb_en", {15'b0, wr_en_wb}, {15'b0, e.we});
            chk("wb_rw", {11'b0, RW_wb}, {11'b0, e.rw});
            chk("wb_data", {8'b0, ans_wb}, {8'b0, e.d});
        end else begin
            chk("wb_en_fill", {15'b0, wr_en_wb}, 16'h0);
        end
    endtask

    task automatic check_cleared(input string nm);
        chk({nm, "_wr_en"}, {15'b0, wr_en_wb}, 16'h0);
        chk({nm, "_ex"}, {8'b0, ans_ex}, 16'h0);
        chk({nm, "_dm"}, {8'b0, ans_dm}, 16'h0);
        chk({nm, "_wb"}, {8'b0, ans_wb}, 16'h0);
        chk({nm, "_rw"}, {11'b0, RW_wb}, 16'h0);
        chk({nm, "_men"}, {15'b0, mem_en_ex}, 16'h0);
        chk({nm, "_mrw"}, {15'b0, mem_rw_ex}, 16'h0);
        chk({nm, "_wdata"}, {8'b0, mem_wdata}, 16'h0);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1;
        check_cleared("rst_mid");
        #2 reset = 1'b1;
        sb.delete();
    endtask

    initial begin
        tbl[0] = '{2'b00, 1'b0, 8'h44, 8'h44};
        tbl[1] = '{2'b01, 1'b0, 8'h11, 8'h11};
        tbl[2] = '{2'b10, 1'b0, 8'h22, 8'h22};
        tbl[3] = '{2'b11, 1'b0, 8'h33, 8'h33};
        tbl[4] = '{2'b00, 1'b1, 8'h07, 8'h44};
        tbl[5] = '{2'b01, 1'b1, 8'h07, 8'h11};
        tbl[6] = '{2'b10, 1'b1, 8'h07, 8'h22};
        tbl[7] = '{2'b11, 1'b1, 8'h07, 8'h33};

        reset = 1'b0;
        op_dec = '0; RW_dec = '0;
        mux_sel_a = '0; mux_sel_b = '0;
        imm_sel = 1'b0; Imm = 8'h07;
        mem_en_dec = 1'b1; mem_rw_dec = 1'b1; mem_mux_sel_dec = 1'b0;
        rd_data_a = '0; rd_data_b = 8'h44;
        alu_result = 8'h5A; mem_rd_data = 8'hA5;

        @(posedge clk);
        #1;
        check_cleared("rst_init");
        #2 reset = 1'b1;

        repeat (3) step(5'b00000, 5'd0, 8'h00, 1'b0);

        step(5'b00000, 5'd5, 8'h3C, 1'b0);
        mux_sel_a = 2'b01;
        #1 chk("fwd_d1", {8'b0, ans_a}, 16'h003C);
        chk("op_exec", {11'b0, op_exec}, 16'h0);
        step(5'b00011, 5'd6, 8'h00, 1'b0);
        mux_sel_a = 2'b10;
        #1 chk("fwd_d2", {8'b0, ans_a}, 16'h003C);
        chk("op_exec2", {11'b0, op_exec}, 16'h0003);
        step(5'b00000, 5'd6, 8'h00, 1'b0);
        mux_sel_a = 2'b11;
        #1 chk("fwd_d3", {8'b0, ans_a}, 16'h003C);
        mux_sel_a = 2'b00;
        rd_data_a = 8'h9E;
        #1 chk("fwd_rf", {8'b0, ans_a}, 16'h009E);

        for (int i = 0; i < 8; i++) begin
            mux_sel_b = 2'b00;
            imm_sel   = 1'b0;
            step(5'b00000, 5'd1, 8'h33, 1'b0);
            step(5'b00000, 5'd2, 8'h22, 1'b0);
            step(5'b00000, 5'd3, 8'h11, 1'b0);
            mux_sel_b = tbl[i].sel;
            imm_sel   = tbl[i].imm;
            #1 chk($sformatf("ans_b[%0d]", i), {8'b0, ans_b},
                   {8'b0, tbl[i].b});
            step(5'b00000, 5'd4, 8'h00, 1'b0);
            chk($sformatf("wdata[%0d]", i), {8'b0, mem_wdata},
                {8'b0, tbl[i].wd});
        end
        mux_sel_b = 2'b00;
        imm_sel   = 1'b0;

        step(5'b10100, 5'd9, 8'h10, 1'b1);
        chk("ld_addr", {8'b0, mem_addr}, 16'h0010);
        chk("ld_men", {15'b0, mem_en_ex}, 16'h1);
        chk("ld_mrw", {15'b0, mem_rw_ex}, 16'h0);
        step(5'b10101, 5'd3, 8'h20, 1'b0);
        chk("ld_dm", {8'b0, ans_dm}, 16'h00A5);
        chk("st_mrw", {15'b0, mem_rw_ex}, 16'h1);
        chk("st_wdata", {8'b0, mem_wdata}, 16'h0044);
        step(5'b11100, 5'd7, 8'h30, 1'b0);
        step(5'b11000, 5'd8, 8'h31, 1'b0);
        step(5'b00000, 5'd10, 8'h32, 1'b0);
        step(5'b00000, 5'd11, 8'h33, 1'b0);

        step(5'b10101, 5'd12, 8'h20, 1'b0);
        step(5'b00000, 5'd13, 8'h21, 1'b0);
        pulse_reset();
        repeat (4) step(5'b00001, 5'd14, 8'h40, 1'b0);

`ifdef FWD_STATS_EN
        pulse_reset();
        chk("cnt_rst", fwd_count, 16'h0);
        mux_sel_a = 2'b01;
        mux_sel_b = 2'b10;
        imm_sel   = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("cnt_6", fwd_count, 16'd6);
        imm_sel = 1'b1;
        @(posedge clk);
        #1 chk("cnt_imm", fwd_count, 16'd7);
        imm_sel = 1'b0;
        repeat (32763) @(posedge clk);
        #1 chk("cnt_fffd", fwd_count, 16'hFFFD);
        mux_sel_b = 2'b00;
        @(posedge clk);
        #1 chk("cnt_fffe", fwd_count, 16'hFFFE);
        mux_sel_b = 2'b11;
        @(posedge clk);
        #1 chk("cnt_sat", fwd_count, 16'hFFFF);
        @(posedge clk);
        #1 chk("cnt_hold", fwd_count, 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
